// File: rtl/eight_to_three_serial_encoder_pkg.sv
// Shared widths, FSM state encoding and bit-count helper for the
// eight-to-three serial encoder.
package eight_to_three_serial_encoder_pkg;

    localparam int IN_W  = 8;
    localparam int IDX_W = 3;

    localparam logic [IN_W-1:0] VEC_ZERO = IN_W'(0);
    localparam logic [IN_W-1:0] VEC_ONE  = IN_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // True when exactly one bit of the vector is set.
    function automatic logic is_single_bit(input logic [IN_W-1:0] vec);
        return (vec != VEC_ZERO) && ((vec & (vec - VEC_ONE)) == VEC_ZERO);
    endfunction

endpackage

// File: rtl/eight_to_three_serial_encoder_bit_index_encoder.sv
// Combinational priority encoder: picks the lowest or highest set bit of
// a vector and flags whether that bit is the only one set.
module bit_index_encoder
    import eight_to_three_serial_encoder_pkg::*;
(
    input  logic [IN_W-1:0]  i_vec,
    input  logic             i_lsb_first,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_single
);

    // Later loop iterations win, so scan order decides which end has priority.
    always_comb begin
        o_idx = IDX_W'(0);
        if (i_lsb_first) begin
            for (int i = IN_W - 1; i >= 0; i--) begin
                o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
            end
        end
    end

    assign o_single = is_single_bit(i_vec);

endmodule

// File: rtl/eight_to_three_serial_encoder.sv
// Serialises every set bit of an accepted 8-bit vector into one 3-bit
// index beat, with valid/ready handshakes on both sides.
module eight_to_three_serial_encoder
    import eight_to_three_serial_encoder_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  inp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out,
    output logic             out_last,
    output logic             zero_err,
    output logic             busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic [IN_W-1:0]   r_pending;
    logic [IN_W-1:0]   w_pending_next;
    logic              r_zero_err;
    logic              w_zero_err_next;
    logic [IDX_W-1:0]  w_idx;
    logic              w_single;
    logic              w_emit;
    logic [IN_W-1:0]   w_clear_mask;

    bit_index_encoder u_bit_index_encoder (
        .i_vec       (r_pending),
        .i_lsb_first (LSB_FIRST),
        .o_idx       (w_idx),
        .o_single    (w_single)
    );

    assign w_emit       = (r_state == EMIT);
    assign w_clear_mask = VEC_ONE << w_idx;

    assign out_valid = w_emit;
    assign busy      = w_emit;
    assign out       = w_emit ? w_idx : IDX_W'(0);
    assign out_last  = w_emit & w_single;
    assign in_ready  = w_emit ? (w_single & out_ready) : 1'b1;
    assign zero_err  = r_zero_err;

    // State, pending vector and zero-error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pending  <= VEC_ZERO;
            r_zero_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pending  <= w_pending_next;
            r_zero_err <= w_zero_err_next;
        end
    end

    // Next-state logic; a last-beat handoff reloads pending without a bubble.
    always_comb begin
        w_state_next    = r_state;
        w_pending_next  = r_pending;
        w_zero_err_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (inp != VEC_ZERO) begin
                        w_pending_next = inp;
                        w_state_next   = EMIT;
                    end else begin
                        w_zero_err_next = 1'b1;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (w_single) begin
                        if (in_valid && (inp != VEC_ZERO)) begin
                            w_pending_next = inp;
                            w_state_next   = EMIT;
                        end else begin
                            w_pending_next  = VEC_ZERO;
                            w_state_next    = IDLE;
                            w_zero_err_next = in_valid;
                        end
                    end else begin
                        w_pending_next = r_pending & ~w_clear_mask;
                    end
                end else begin
                    w_pending_next = r_pending;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_pending_next = VEC_ZERO;
            end
        endcase
    end

endmodule

// File: tb/tb_eight_to_three_serial_encoder.sv
// Scoreboard bench: drivers push hand-computed beats when a vector is
// accepted; per-DUT monitors compare every presented beat on the falling edge.
module tb_eight_to_three_serial_encoder;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic [7:0] inp0 = 8'h00, inp1 = 8'h00;
    logic       out_ready0 = 1'b1, out_ready1 = 1'b1;
    logic       in_ready0, in_ready1, out_valid0, out_valid1;
    logic [2:0] out0, out1;
    logic       out_last0, out_last1, zero_err0, zero_err1, busy0, busy1;

    int checks   = 0;
    int failures = 0;
    beat_t q0[$];
    beat_t q1[$];

    always #5 clk = ~clk;

    eight_to_three_serial_encoder #(.LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .inp(inp0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out(out0), .out_last(out_last0),
        .zero_err(zero_err0), .busy(busy0)
    );

    eight_to_three_serial_encoder #(.LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .inp(inp1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out(out1), .out_last(out_last1),
        .zero_err(zero_err1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Offer vec to one DUT; push its n expected beats (idx k at idxs[3k+:3]) once accepted.
    task automatic send(input bit which, input logic [7:0] vec, input int n, input logic [23:0] idxs);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (which == 1'b0) begin in_valid0 = 1'b1; inp0 = vec; end
        else               begin in_valid1 = 1'b1; inp1 = vec; end
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if ((which == 1'b0) ? in_ready0 : in_ready1) begin
                got = 1'b1;
                for (int k = 0; k < n; k++) begin
                    if (which == 1'b0) q0.push_back('{idxs[3*k +: 3], (k == n - 1)});
                    else               q1.push_back('{idxs[3*k +: 3], (k == n - 1)});
                end
            end
        end
        if (!got) fail_now("accept");
    endtask

    // Drop in_valid and run until the DUT leaves EMIT, optionally toggling out_ready.
    task automatic drain(input bit which, input bit toggle);
        bit done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            if (which == 1'b0) begin
                in_valid0 = 1'b0;
                if (toggle) out_ready0 = ~out_ready0;
            end else begin
                in_valid1 = 1'b0;
                if (toggle) out_ready1 = ~out_ready1;
            end
            @(negedge clk);
            done = (which == 1'b0) ? !busy0 : !busy1;
        end
        if (!done) fail_now("drain");
        if (which == 1'b0) begin
            out_ready0 = 1'b1;
            chk("q0_empty", q0.size(), 0);
            chk("idle_in_ready0", in_ready0, 1'b1);
        end else begin
            out_ready1 = 1'b1;
            chk("q1_empty", q1.size(), 0);
            chk("idle_in_ready1", in_ready1, 1'b1);
        end
    endtask

    // Monitor for the LSB-first DUT.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid0) begin
                if (q0.size() == 0) begin
                    chk("dut0_unexpected_beat", {29'd0, out0}, 32'hFFFF_FFFF);
                end else begin
                    chk("dut0_out", out0, q0[0].idx);
                    chk("dut0_last", out_last0, q0[0].last);
                    if (out_ready0) void'(q0.pop_front());
                end
            end else begin
                chk("dut0_idle_out", {out0, out_last0}, 4'd0);
            end
        end
    end

    // Monitor for the MSB-first DUT.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    chk("dut1_unexpected_beat", {29'd0, out1}, 32'hFFFF_FFFF);
                end else begin
                    chk("dut1_out", out1, q1[0].idx);
                    chk("dut1_last", out_last1, q1[0].last);
                    if (out_ready1) void'(q1.pop_front());
                end
            end else begin
                chk("dut1_idle_out", {out1, out_last1}, 4'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        @(negedge clk);
        chk("rst_in_ready", in_ready0, 1'b1);
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_out", {out0, out_last0}, 4'd0);
        chk("rst_zero_err", zero_err0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 0010_0100 -> 2, 5(last).
        send(1'b0, 8'b0010_0100, 2, 24'({3'd5, 3'd2}));
        drain(1'b0, 1'b0);

        // FF with out_ready toggling -> 0..7, stable while stalled.
        send(1'b0, 8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
        drain(1'b0, 1'b1);

        // Zero vector: accepted, one-cycle zero_err, no beats.
        send(1'b0, 8'h00, 0, 24'd0);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("zero_err_pulse", zero_err0, 1'b1);
        chk("zero_no_valid", out_valid0, 1'b0);
        @(negedge clk);
        chk("zero_err_clear", zero_err0, 1'b0);

        // Back-to-back 80 then 01, no bubble.
        send(1'b0, 8'h80, 1, 24'({3'd7}));
        send(1'b0, 8'h01, 1, 24'({3'd0}));
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("b2b_busy", busy0, 1'b1);
        chk("b2b_valid", out_valid0, 1'b1);
        drain(1'b0, 1'b0);

        // MSB-first: 1000_0011 -> 7, 1, 0.
        send(1'b1, 8'b1000_0011, 3, 24'({3'd0, 3'd1, 3'd7}));
        drain(1'b1, 1'b0);

        // Reset during the second beat of FF.
        send(1'b0, 8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        q0.delete();
        #1;
        chk("midrst_out_valid", out_valid0, 1'b0);
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_in_ready", in_ready0, 1'b1);
        chk("midrst_pending", dut0.r_pending, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) @(negedge clk);
        chk("post_rst_in_ready", in_ready0, 1'b1);
        chk("post_rst_busy", busy0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
